// File: rtl/vga_frame_read_ctrl.sv
// vga_frame_read_ctrl: gates FIFO pops to a display window, aligns camera frames to VGA frames,
// expands RGB565 to RGB888 (or luma when VGA_FRC_GRAY_EN is defined) and tracks underruns. Rev 1.0
`default_nettype none

module vga_frame_read_ctrl #(
  parameter int WIN_X0         = 0,
  parameter int WIN_W          = 160,
  parameter int WIN_H          = 120,
  parameter int STARTUP_FRAMES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] pixel_x,
  input  logic [11:0] pixel_y,
  input  logic        empty_fifo,
  input  logic [15:0] din,
  output logic        rd_en,
  output logic [7:0]  vga_out_r,
  output logic [7:0]  vga_out_g,
  output logic [7:0]  vga_out_b,
  output logic        pix_valid,
  output logic        underrun,
  output logic [15:0] underrun_cnt,
  output logic [15:0] frame_cnt
);

  localparam logic [11:0] c_x0    = 12'(WIN_X0);
  localparam logic [11:0] c_w     = 12'(WIN_W);
  localparam logic [11:0] c_h     = 12'(WIN_H);
  localparam logic [11:0] c_xlast = 12'(WIN_X0 + WIN_W - 1);
  localparam logic [11:0] c_ylast = 12'(WIN_H - 1);
  localparam logic [7:0]  c_sf    = 8'(STARTUP_FRAMES);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_ARMED   = 2'd1,
    ST_DISPLAY = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  startup_cnt_q;
  logic [7:0]  r_q, g_q, b_q;
  logic        pix_valid_q;
  logic        underrun_q;
  logic [15:0] underrun_cnt_q;
  logic [15:0] frame_cnt_q;

  // Offset compare: columns left of the window wrap to a large value and fall out of range.
  logic [11:0] w_dx;
  logic        w_in_win;
  logic        w_win_start;
  logic        w_win_end;
  logic        w_tick;
  logic [7:0]  w_startup_nxt;

  assign w_dx          = pixel_x - c_x0;
  assign w_in_win      = (w_dx < c_w) && (pixel_y < c_h);
  assign w_win_start   = (pixel_x == c_x0) && (pixel_y == 12'd0);
  assign w_win_end     = (pixel_x == c_xlast) && (pixel_y == c_ylast);
  assign w_tick        = (pixel_x == 12'd0) && (pixel_y == 12'd0);
  assign w_startup_nxt = startup_cnt_q + 8'd1;

  always_comb begin
    rd_en = 1'b0;
    case (state_q)
      ST_ARMED:   rd_en = w_win_start & ~empty_fifo;
      ST_DISPLAY: rd_en = w_in_win & ~empty_fifo;
      default:    rd_en = 1'b0;
    endcase
  end

  logic [7:0] w_r8, w_g8, w_b8;
  logic [7:0] w_out_r, w_out_g, w_out_b;

  assign w_r8 = {din[15:11], din[15:13]};
  assign w_g8 = {din[10:5], din[10:9]};
  assign w_b8 = {din[4:0], din[4:2]};

`ifdef VGA_FRC_GRAY_EN
  // Weights sum to 256, so the 16-bit sum peaks at 255*256 and never overflows.
  logic [15:0] w_luma_sum;
  assign w_luma_sum = 16'd77 * {8'd0, w_r8} + 16'd150 * {8'd0, w_g8} + 16'd29 * {8'd0, w_b8};
  assign w_out_r    = w_luma_sum[15:8];
  assign w_out_g    = w_luma_sum[15:8];
  assign w_out_b    = w_luma_sum[15:8];
`else
  assign w_out_r = w_r8;
  assign w_out_g = w_g8;
  assign w_out_b = w_b8;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_STARTUP;
      startup_cnt_q  <= 8'd0;
      r_q            <= 8'd0;
      g_q            <= 8'd0;
      b_q            <= 8'd0;
      pix_valid_q    <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= 16'd0;
      frame_cnt_q    <= 16'd0;
    end else begin
      pix_valid_q <= rd_en;
      r_q         <= rd_en ? w_out_r : 8'd0;
      g_q         <= rd_en ? w_out_g : 8'd0;
      b_q         <= rd_en ? w_out_b : 8'd0;

      case (state_q)
        ST_STARTUP: begin
          if (w_tick) begin
            startup_cnt_q <= w_startup_nxt;
            if (w_startup_nxt == c_sf) state_q <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (w_win_start && !empty_fifo) begin
            state_q    <= ST_DISPLAY;
            underrun_q <= 1'b0;
          end
        end
        ST_DISPLAY: begin
          if (w_in_win && empty_fifo) begin
            underrun_q <= 1'b1;
            if (underrun_cnt_q != 16'hFFFF) underrun_cnt_q <= underrun_cnt_q + 16'd1;
          end
          if (w_win_end) begin
            state_q     <= ST_ARMED;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end
        end
        default: begin
          state_q       <= ST_STARTUP;
          startup_cnt_q <= 8'd0;
        end
      endcase
    end
  end

  assign vga_out_r    = r_q;
  assign vga_out_g    = g_q;
  assign vga_out_b    = b_q;
  assign pix_valid    = pix_valid_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

`default_nettype wire

// File: doc/vga_frame_read_ctrl.md
# vga_frame_read_ctrl

Sequences pixel reads from the camera-side asynchronous FIFO into the VGA pixel stream. It sits between the async FIFO read port and the VGA output pins, in the 25 MHz VGA clock domain, driven by the `vga_core` pixel coordinates. It gates reads to a programmable display window, aligns each camera frame to the VGA frame start, and converts RGB565 to 8-bit-per-channel output. It also detects and counts FIFO underruns.

## Interface
Parameters:
- `WIN_X0`, 0 — first visible column of the window.
- `WIN_W`, 160 — window width in pixels.
- `WIN_H`, 120 — window height in lines; rows are 0..`WIN_H`-1.
- `STARTUP_FRAMES`, 1 — VGA frames to wait after reset before arming. Range 1..255.

Ports:
- `clk` in 1 — 25 MHz VGA pixel clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `pixel_x` in 12 — current column from `vga_core`.
- `pixel_y` in 12 — current row from `vga_core`.
- `empty_fifo` in 1 — async FIFO empty flag. The FIFO is first-word-fall-through, so `din` is valid whenever this is 0.
- `din` in 16 — FIFO head word in RGB565 format: [15:11] R, [10:5] G, [4:0] B.
- `rd_en` out 1 — FIFO pop. Combinational.
- `vga_out_r`, `vga_out_g`, `vga_out_b` out 8 each — registered pixel colour.
- `pix_valid` out 1 — registered; 1 when the colour outputs carry FIFO data.
- `underrun` out 1 — registered sticky flag. Cleared when the block next enters DISPLAY.
- `underrun_cnt` out 16 — saturating count of underrun pixels.
- `frame_cnt` out 16 — count of completed frames. Wraps.

## Operation
Terms:
- In-window (combinational): `pixel_x` in [`WIN_X0`, `WIN_X0`+`WIN_W`-1] and `pixel_y` < `WIN_H`.
- Window start: `pixel_x`==`WIN_X0` and `pixel_y`==0.
- Window end: `pixel_x`==`WIN_X0`+`WIN_W`-1 and `pixel_y`==`WIN_H`-1.
- Frame tick: `pixel_x`==0 and `pixel_y`==0.

State machine (2-bit, reset to STARTUP):
- **STARTUP**
  - An 8-bit counter increments on each frame tick.
  - When the count reaches `STARTUP_FRAMES`, move to ARMED.
  - `rd_en`=0.
- **ARMED**
  - At window start with `empty_fifo`=0: assert `rd_en`, go to DISPLAY, clear `underrun`.
  - At window start with `empty_fifo`=1: stay in ARMED; no pop; no underrun counted.
- **DISPLAY**
  - When in-window and `empty_fifo`=0: `rd_en`=1.
  - When in-window and `empty_fifo`=1: `rd_en`=0, set `underrun`, and increment `underrun_cnt` (saturating at 0xFFFF). Pixels are not re-fetched; the frame continues.
  - At window end, go to ARMED and increment `frame_cnt`, whether or not the last pixel underran.
- The 4th state encoding is illegal and returns to STARTUP on the next clock.

Colour conversion, registered on the same edge that `rd_en` pops:
- R8 = {R5, R5[4:2]}
- G8 = {G6, G6[5:4]}
- B8 = {B5, B5[4:2]}

Pixel output rules:
- On a pop: `pix_valid`=1 and outputs carry the converted colour.
- On every other cycle (outside the window, underrun, STARTUP, ARMED without pop): outputs=0 and `pix_valid`=0.
- `rd_en` never asserts while `empty_fifo`=1.

## Timing
- Reset values: all colour outputs 0, `pix_valid` 0, `underrun` 0, `underrun_cnt` 0, `frame_cnt` 0, state STARTUP, startup counter 0. `rd_en` is 0 in reset because it is decoded from STARTUP.
- Latency: 1 clock from coordinate to colour. The coordinate at edge N appears on the outputs after edge N+1.
- Simultaneous events:
  - A frame tick that coincides with window start (`WIN_X0`=0) in STARTUP only counts. Arming happens at the next window start, one frame later.
  - Window end and underrun on the same cycle: both the underrun and `frame_cnt` increments occur.
- Reset asserted mid-frame: all state is cleared immediately. After release, the full STARTUP wait repeats. The FIFO is not flushed by this block.
- Width rules: window compares are 12-bit unsigned. `WIN_X0`+`WIN_W`-1 must be ≤ 639 and `WIN_H` ≤ 480; violating values are unsupported.

## Configuration
- `VGA_FRC_GRAY_EN` defined: all three channels output luma Y = (77·R8 + 150·G8 + 29·B8) >> 8.
  - The sum is computed in 16 bits with no overflow; max is 65280.
  - The result is registered in the same cycle, so latency stays 1.
- `VGA_FRC_GRAY_EN` undefined: per-channel RGB565 expansion as above.

## Test plan
- Reset release with `STARTUP_FRAMES`=2 and a non-empty FIFO -> `rd_en` stays 0 through 2 frame ticks; the first pop occurs at (`WIN_X0`,0) of frame 3.
- Full 160×120 frame with the FIFO always non-empty -> exactly 19200 pops, `frame_cnt`=1, `underrun_cnt`=0, no pops outside the window.
- `din`=0xF800 popped -> next cycle R=0xFF, G=0x00, B=0x00, `pix_valid`=1. `din`=0x0410 -> G=0x82.
- FIFO empty for 5 in-window cycles mid-frame -> `underrun`=1, `underrun_cnt`=5, outputs 0 on those cycles, `frame_cnt` still increments at window end.
- FIFO empty at window start -> stays ARMED for the whole frame, zero pops, `underrun_cnt` unchanged. FIFO non-empty at the next start -> DISPLAY.
- With `VGA_FRC_GRAY_EN`, `din`=0xFFFF -> R=G=B=0xFF. Reset pulse mid-frame -> outputs 0 and `rd_en` 0 within the same cycle; STARTUP repeats.
